// File: rtl/dd_enqueue_tracker_pkg.sv
// Shared widths and thresholds for the dd_engine enqueue tracker, plus clogb2 for index widths.
package dd_enqueue_tracker_pkg;

  localparam int FLAG_W                 = 1;
  localparam int PKT_QUEUE_IND_W        = 4;
  localparam int PKT_QUEUE_START_THRESH = 2;
  localparam int PKT_QUEUE_STOP_THRESH  = 4;
  localparam int DD_FLOW_CNT            = 16;

  typedef logic [FLAG_W-1:0] flag_t;

  function automatic int clogb2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/dd_flow_qsize_table.sv
// Per-flow queue size / back-pressure table; applies clr, enq and deq updates at one edge.
module dd_flow_qsize_table
  import dd_enqueue_tracker_pkg::*;
#(
  parameter int FLOW_CNT     = DD_FLOW_CNT,
  parameter int FLOW_ID_W    = clogb2(DD_FLOW_CNT),
  parameter int QSIZE_W      = PKT_QUEUE_IND_W,
  parameter int STOP_THRESH  = PKT_QUEUE_STOP_THRESH,
  parameter int START_THRESH = PKT_QUEUE_START_THRESH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enq_en,
  input  logic [FLOW_ID_W-1:0] enq_flow_id,
  input  logic                 deq_en,
  input  logic [FLOW_ID_W-1:0] deq_flow_id,
  input  logic                 clr_en,
  input  logic [FLOW_ID_W-1:0] clr_flow_id,
  output logic [QSIZE_W-1:0]   enq_size,
  output flag_t                enq_bp,
  output flag_t                enq_dropped,
  output flag_t                enq_deact
);

  localparam logic [QSIZE_W-1:0] STOP_Q  = QSIZE_W'(STOP_THRESH);
  localparam logic [QSIZE_W-1:0] START_Q = QSIZE_W'(START_THRESH);

  logic [QSIZE_W-1:0] size_q [FLOW_CNT];
  logic [QSIZE_W-1:0] size_d [FLOW_CNT];
  logic               bp_q   [FLOW_CNT];
  logic               bp_d   [FLOW_CNT];
  logic               sat_hit;

  // Enqueue applies first, then dequeue on the intermediate value, then clear overrides both.
  always_comb begin
    for (int i = 0; i < FLOW_CNT; i++) begin
      size_d[i] = size_q[i];
      bp_d[i]   = bp_q[i];
      if (enq_en && (enq_flow_id == FLOW_ID_W'(i)) && !(&size_q[i])) begin
        size_d[i] = size_q[i] + 1'b1;
        bp_d[i]   = bp_q[i] | (size_d[i] >= STOP_Q);
      end
      if (deq_en && (deq_flow_id == FLOW_ID_W'(i))) begin
        if (size_d[i] != '0) size_d[i] = size_d[i] - 1'b1;
        bp_d[i] = bp_d[i] & (size_d[i] >= START_Q);
      end
      if (clr_en && (clr_flow_id == FLOW_ID_W'(i))) begin
        size_d[i] = '0;
        bp_d[i]   = 1'b0;
      end
    end
  end

  // A clear on the same flow wins, so a saturated entry being torn down is not a drop.
  assign sat_hit     = (&size_q[enq_flow_id]) & ~(clr_en & (clr_flow_id == enq_flow_id));
  assign enq_size    = size_d[enq_flow_id];
  assign enq_bp      = bp_d[enq_flow_id];
  assign enq_dropped = sat_hit;
  assign enq_deact   = bp_d[enq_flow_id] & ~bp_q[enq_flow_id] & ~sat_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FLOW_CNT; i++) begin
        size_q[i] <= '0;
        bp_q[i]   <= 1'b0;
      end
    end else begin
      size_q <= size_d;
      bp_q   <= bp_d;
    end
  end

endmodule

// File: rtl/dd_enqueue_tracker.sv
// Enqueue-side occupancy/back-pressure tracker: one registered result beat per accepted enqueue.
// Optional saturating drop counter enabled by DD_ENQ_DROP_CNT_EN.
module dd_enqueue_tracker
  import dd_enqueue_tracker_pkg::*;
#(
  parameter int FLOW_CNT     = DD_FLOW_CNT,
  parameter int FLOW_ID_W    = clogb2(DD_FLOW_CNT),
  parameter int QSIZE_W      = PKT_QUEUE_IND_W,
  parameter int STOP_THRESH  = PKT_QUEUE_STOP_THRESH,
  parameter int START_THRESH = PKT_QUEUE_START_THRESH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enq_valid,
  input  logic [FLOW_ID_W-1:0] enq_flow_id,
  output logic                 enq_ready,
  input  logic                 deq_upd_valid,
  input  logic [FLOW_ID_W-1:0] deq_upd_flow_id,
  input  logic                 clr_valid,
  input  logic [FLOW_ID_W-1:0] clr_flow_id,
`ifdef DD_ENQ_DROP_CNT_EN
  output logic [15:0]          drop_cnt,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [FLOW_ID_W-1:0] out_flow_id,
  output logic [QSIZE_W-1:0]   pkt_queue_size_out,
  output flag_t                back_pressure_out,
  output flag_t                deactivated_by_ep,
  output flag_t                enq_dropped
);

  logic               enq_fire;
  logic [QSIZE_W-1:0] t_size;
  flag_t              t_bp;
  flag_t              t_dropped;
  flag_t              t_deact;

  // A stalled result blocks new enqueues so the table only advances for reported beats.
  assign enq_ready = ~out_valid | out_ready;
  assign enq_fire  = enq_valid & enq_ready;

  dd_flow_qsize_table #(
    .FLOW_CNT    (FLOW_CNT),
    .FLOW_ID_W   (FLOW_ID_W),
    .QSIZE_W     (QSIZE_W),
    .STOP_THRESH (STOP_THRESH),
    .START_THRESH(START_THRESH)
  ) u_table (
    .clk        (clk),
    .rst        (rst),
    .enq_en     (enq_fire),
    .enq_flow_id(enq_flow_id),
    .deq_en     (deq_upd_valid),
    .deq_flow_id(deq_upd_flow_id),
    .clr_en     (clr_valid),
    .clr_flow_id(clr_flow_id),
    .enq_size   (t_size),
    .enq_bp     (t_bp),
    .enq_dropped(t_dropped),
    .enq_deact  (t_deact)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid          <= 1'b0;
      out_flow_id        <= '0;
      pkt_queue_size_out <= '0;
      back_pressure_out  <= '0;
      deactivated_by_ep  <= '0;
      enq_dropped        <= '0;
    end else if (enq_fire) begin
      out_valid          <= 1'b1;
      out_flow_id        <= enq_flow_id;
      pkt_queue_size_out <= t_size;
      back_pressure_out  <= t_bp;
      deactivated_by_ep  <= t_deact;
      enq_dropped        <= t_dropped;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef DD_ENQ_DROP_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (enq_fire && t_dropped[0] && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule
